// File: rtl/xor_arbiter.sv
// Four-requester round-robin arbiter sharing one registered WIDTH-bit XOR unit.
// Grant is combinational in IDLE; the result is registered and held until accepted.
module xor_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*WIDTH-1:0]   req_a,
  input  logic [4*WIDTH-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic [1:0]           resp_id,
  output logic                 busy
);

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       last_grant;
  logic [1:0]       grant_id;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [1:0]       grant_idx_c;
  logic             grant_any_c;
  logic [1:0]       search_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting one past the last completed grant
  always_comb begin
    grant_idx_c = 2'd0;
    grant_any_c = 1'b0;
    search_idx  = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = 2'(last_grant + 2'(k + 1));
      if (!grant_any_c && req_valid[search_idx]) begin
        grant_any_c = 1'b1;
        grant_idx_c = search_idx;
      end
    end
  end

  assign req_ready = (RST_N && state == IDLE && grant_any_c) ? (4'b0001 << grant_idx_c) : 4'b0000;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      grant_id   <= 2'd0;
      lat_a      <= '0;
      lat_b      <= '0;
      resp_data  <= '0;
      resp_id    <= 2'd0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any_c) begin
            lat_a    <= a_arr[grant_idx_c];
            lat_b    <= b_arr[grant_idx_c];
            grant_id <= grant_idx_c;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          resp_data  <= lat_a ^ lat_b;
          resp_id    <= grant_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // Result and id stay frozen until the consumer takes them
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed bench for xor_arbiter: reset, rotation, backpressure, wrap fairness,
// mid-transaction reset and edge operands, with hand-computed expectations.
module tb_xor_arbiter;

  localparam int unsigned WIDTH = 8;

  logic               CLK;
  logic               RST_N;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_data;
  logic [1:0]         resp_id;
  logic               busy;

  int checks;
  int errors;

  xor_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1ns past the next rising edge; inputs are driven there
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic test_reset();
    RST_N      = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data: got %h expected 00", resp_data); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    req_valid = 4'b0000;
    RST_N     = 1'b1;
    #1;
  endtask

  task automatic test_rotation();
    logic [7:0] a_tab [4];
    logic [7:0] b_tab [4];
    logic [7:0] x_tab [4];
    int exp_id [5];
    a_tab = '{8'h12, 8'h34, 8'h56, 8'h78};
    b_tab = '{8'hF0, 8'h0F, 8'hFF, 8'h81};
    x_tab = '{8'hE2, 8'h3B, 8'hA9, 8'hF9};
    exp_id = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_op(i, a_tab[i], b_tab[i]);
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++; if (req_ready !== (4'b0001 << exp_id[n])) begin errors++; $display("FAIL rot_grant%0d: got %b expected id %0d", n, req_ready, exp_id[n]); end
      tick();
      checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL rot_compute%0d: ready %b busy %b expected 0000/1", n, req_ready, busy); end
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(exp_id[n]) || resp_data !== x_tab[exp_id[n]]) begin
        errors++; $display("FAIL rot_resp%0d: valid %b id %0d data %h expected 1/%0d/%h", n, resp_valid, resp_id, resp_data, exp_id[n], x_tab[exp_id[n]]);
      end
      tick();
      if (n == 4) req_valid = 4'b0000;
      #1;
    end
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rot_end: valid %b busy %b expected 0/0", resp_valid, busy); end
  endtask

  task automatic test_single();
    set_op(0, 8'hA5, 8'h0F);
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_compute: ready %b valid %b expected 0000/0", req_ready, resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'hAA || resp_id !== 2'd0) begin
      errors++; $display("FAIL single_resp: valid %b data %h id %0d expected 1/aa/0", resp_valid, resp_data, resp_id);
    end
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 8'hAA || resp_id !== 2'd0) begin
      errors++; $display("FAIL single_retain: valid %b busy %b data %h id %0d expected 0/0/aa/0", resp_valid, busy, resp_data, resp_id);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    set_op(1, 8'h3C, 8'h5A);
    set_op(2, 8'h11, 8'h22);
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = 4'b1111;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h66 || resp_id !== 2'd1) begin
      errors++; $display("FAIL bp_resp: valid %b data %h id %0d expected 1/66/1", resp_valid, resp_data, resp_id);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_data !== 8'h66 || resp_id !== 2'd1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d: valid %b data %h id %0d busy %b ready %b", c, resp_valid, resp_data, resp_id, busy, req_ready);
      end
    end
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_done: valid %b busy %b expected 0/0", resp_valid, busy); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_waiting_grant: got %b expected 0100", req_ready); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_wrap_fairness();
    set_op(3, 8'hC3, 8'h0C);
    set_op(0, 8'h01, 8'h80);
    req_valid  = 4'b1000;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_g3: got %b expected 1000", req_ready); end
    tick(); tick(); tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b expected 0001", req_ready); end
    tick(); tick();
    checks++; if (resp_id !== 2'd0 || resp_data !== 8'h81) begin errors++; $display("FAIL wrap_resp0: id %0d data %h expected 0/81", resp_id, resp_data); end
    tick();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_second: got %b expected 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (resp_id !== 2'd3 || resp_data !== 8'hCF) begin errors++; $display("FAIL wrap_resp3: id %0d data %h expected 3/cf", resp_id, resp_data); end
    tick();
  endtask

  task automatic test_reset_mid_compute();
    set_op(2, 8'h99, 8'h66);
    req_valid  = 4'b0100;
    resp_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    RST_N     = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_ctrl: busy %b valid %b ready %b expected 0/0/0000", busy, resp_valid, req_ready);
    end
    checks++; if (resp_data !== 8'h00 || resp_id !== 2'd0) begin errors++; $display("FAIL rst_mid_data: data %h id %0d expected 00/0", resp_data, resp_id); end
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_resp%0d: valid %b busy %b expected 0/0", c, resp_valid, busy); end
    end
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_regrant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_data !== 8'hFF || resp_id !== 2'd2) begin
      errors++; $display("FAIL rst_resp: valid %b data %h id %0d expected 1/ff/2", resp_valid, resp_data, resp_id);
    end
    tick();
  endtask

  task automatic test_edge_operands();
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    logic [7:0] ex [3];
    ea = '{8'hFF, 8'h00, 8'h55};
    eb = '{8'hFF, 8'hFF, 8'hAA};
    ex = '{8'h00, 8'hFF, 8'hFF};
    resp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_op(1, ea[n], eb[n]);
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0000;
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_data !== ex[n] || resp_id !== 2'd1) begin
        errors++; $display("FAIL edge%0d: valid %b data %h id %0d expected 1/%h/1", n, resp_valid, resp_data, resp_id, ex[n]);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotation();
    test_single();
    test_back_to_back_backpressure();
    test_wrap_fairness();
    test_reset_mid_compute();
    test_edge_operands();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 1..32).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  4  per-requester request strobe; bit i belongs to requester i.
REQ-005 Port: req_ready  output  4  per-requester grant/accept, one-hot or zero.
REQ-006 Port: req_a  input  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: req_b  input  4*WIDTH  operand B; same packing as req_a.
REQ-008 Port: resp_valid  output  1  result available.
REQ-009 Port: resp_ready  input  1  consumer accepts result.
REQ-010 Port: resp_data  output  WIDTH  XOR result of the granted operands.
REQ-011 Port: resp_id  output  2  index of the requester that owns resp_data.
REQ-012 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL share one registered WIDTH-bit XOR unit among 4 requesters via an FSM with states IDLE, COMPUTE and RESP.
REQ-014 In IDLE with req_valid == 0, the FSM SHALL remain in IDLE, with req_ready == 0.
REQ-015 In IDLE with any req_valid bit set, the block SHALL combinationally assert exactly one req_ready bit, the grant g.
- g is the first set req_valid bit searched round-robin from (last_grant+1) mod 4.
- The same edge latches req_a[g], req_b[g] and g, and moves the FSM to COMPUTE.
REQ-016 A request transfer SHALL occur only on a cycle where req_valid[i] and req_ready[i] are both high.
- req_ready SHALL be 0 in COMPUTE and RESP.
REQ-017 In COMPUTE, the block SHALL register resp_data = latched_a ^ latched_b and resp_id = g, then move to RESP.
REQ-018 In RESP, resp_valid SHALL be 1, and resp_data and resp_id SHALL be held stable until the cycle resp_ready is high.
REQ-019 On the RESP cycle with resp_ready high, the FSM SHALL return to IDLE and set last_grant to g.
REQ-020 Latency SHALL be 2 cycles from a request transfer to resp_valid high.
- Minimum spacing between grants is 3 cycles (IDLE, COMPUTE, RESP with resp_ready held high).
REQ-021 A requester deasserting req_valid before being granted SHALL be dropped without side effects.
- Requesters hold operands stable while req_valid is high.
REQ-022 Requests arriving during COMPUTE or RESP SHALL wait, and are arbitrated on the next IDLE cycle.
- There is no request queue beyond the req_valid inputs themselves.
REQ-023 With all four requesters continuously valid, grants SHALL rotate 0,1,2,3,0...
- No requester waits more than 3 other grants.
REQ-024 last_grant SHALL wrap from 3 to 0.
REQ-025 Upper operand bits SHALL NOT be truncated or extended; result width equals WIDTH exactly.
REQ-026 resp_data and resp_id SHALL retain their last values outside RESP, while resp_valid is 0.

Reset
REQ-027 While RST_N is low, the block SHALL hold these values:
- FSM = IDLE; req_ready = 0; resp_valid = 0; busy = 0.
- resp_data = 0; resp_id = 0; last_grant = 3, so the first search starts at requester 0.
REQ-028 Reset asserted mid-transaction (COMPUTE or RESP) SHALL abort it immediately.
- The response is not produced after RST_N rises.
REQ-029 After RST_N deasserts, the first grant SHALL be possible on the first rising edge.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Single request, WIDTH=8: req_valid=0001, a0=0xA5, b0=0x0F, resp_ready=1 -> req_ready=0001 for one cycle; 2 cycles later resp_valid=1, resp_data=0xAA, resp_id=0.
- All four valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; each resp_data equals the matching a^b; one response every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_data and resp_id stable, busy=1, req_ready=0 throughout; completes on the cycle resp_ready rises.
- Fairness after wrap: last grant 3, then req_valid=1001 -> next grant is requester 0, then requester 3.
- Reset mid-COMPUTE: pull RST_N low -> all outputs at reset values; no resp_valid after release; next request is granted normally.
- Edge operands: a=0xFF, b=0xFF -> 0x00; a=0x00, b=0xFF -> 0xFF; a=0x55, b=0xAA -> 0xFF.
